// File: rtl/gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync
//
// Synchronises a Gray-coded async-FIFO pointer from a foreign clock domain into
// the CLK domain. It provides the synchronised Gray value, a registered binary
// conversion, a one-cycle update strobe on every pointer change and a sticky
// flag for illegal (multi-bit) Gray transitions.
//
// Parameters
//   PTR_WIDTH   pointer width in bits, address bits + wrap bit   (2..16)
//   NUM_STAGES  synchroniser flop stages                         (2..4)
//
// Ports
//   CLK           in   destination-domain clock
//   RST           in   asynchronous active-low reset
//   ptr_in        in   Gray pointer from the foreign domain, asynchronous to CLK
//   err_clr       in   synchronous clear of gray_err
//   ptr_gray_out  out  synchronised Gray pointer (last sync stage)
//   ptr_bin_out   out  registered binary equivalent of ptr_gray_out
//   ptr_upd       out  one-cycle strobe: ptr_bin_out has just taken a new value
//   gray_err      out  sticky flag: illegal Gray transition seen
// -----------------------------------------------------------------------------
module gray_ptr_sync #(
    parameter int PTR_WIDTH  = 4,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PTR_WIDTH-1:0] ptr_in,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] ptr_gray_out,
    output logic [PTR_WIDTH-1:0] ptr_bin_out,
    output logic                 ptr_upd,
    output logic                 gray_err
);

    // Reject out-of-range configurations at elaboration time.
    if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: NUM_STAGES must be in 2..4");
    end
    if (PTR_WIDTH < 2 || PTR_WIDTH > 16) begin : g_bad_width
        $error("gray_ptr_sync: PTR_WIDTH must be in 2..16");
    end

    // -------------------------------------------------------------------------
    // Synchroniser chain: every bit goes through exactly NUM_STAGES flops with
    // nothing in between, so each bit resolves independently and Gray coding
    // bounds the sampled value to old-or-new.
    // -------------------------------------------------------------------------
    logic [PTR_WIDTH-1:0] sync_q [NUM_STAGES];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the sync chain is a small flop array, not a RAM, so it can
            // and must be reset element by element; otherwise a stale value
            // from before reset would emerge as a spurious update.
            for (int i = 0; i < NUM_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value; blocking ones would collapse the
            // chain into a single flop.
            sync_q[0] <= ptr_in;
            for (int i = 1; i < NUM_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ptr_gray_out = sync_q[NUM_STAGES-1];

    // -------------------------------------------------------------------------
    // Change detection, binary conversion and error tracking, all working on
    // the synchronised value only.
    // -------------------------------------------------------------------------
    logic [PTR_WIDTH-1:0] prev_q;
    logic [PTR_WIDTH-1:0] diff;
    logic [PTR_WIDTH-1:0] bin_d, bin_q;
    logic                 upd_d, upd_q;
    logic                 err_d, err_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through it can leave a value unassigned and infer a latch.
        bin_d = '0;
        diff  = ptr_gray_out ^ prev_q;
        // bin[i] is the XOR of all Gray bits from i up to the MSB, which is the
        // unrolled form of bin[i] = bin[i+1] ^ gray[i].
        for (int i = 0; i < PTR_WIDTH; i++) begin
            bin_d[i] = ^(ptr_gray_out >> i);
        end
        upd_d = |diff;
        // A set condition beats a simultaneous clear.
        err_d = ($countones(diff) > 1) || (err_q && !err_clr);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q <= '0;
            bin_q  <= '0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= ptr_gray_out;
            bin_q  <= bin_d;
            upd_q  <= upd_d;
            err_q  <= err_d;
        end
    end

    assign ptr_bin_out = bin_q;
    assign ptr_upd     = upd_q;
    assign gray_err    = err_q;

endmodule
